// File: rtl/time_keeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper_pkg
// Description : Shared constants, format encoding and hour-conversion helper
//               for the time_keeper block.
//               Items: CLK_HZ_DEFAULT, SEC_MAX, MIN_MAX, H24_MAX, H12_MAX,
//               fmt_e (FMT_24H / FMT_12H), hour_t, conv_hour().
// Revision    : 1.0 - initial release
// ============================================================================
package time_keeper_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

    localparam logic [7:0] SEC_MAX = 8'd59;
    localparam logic [7:0] MIN_MAX = 8'd59;
    localparam logic [7:0] H24_MAX = 8'd23;
    localparam logic [7:0] H12_MAX = 8'd12;

    typedef enum logic {
        FMT_24H = 1'b0,
        FMT_12H = 1'b1
    } fmt_e;

    typedef struct packed {
        logic [7:0] hour;
        logic       pm;
    } hour_t;

    // Re-express a held hour in the target format. The pm input is only
    // meaningful when converting from 12h; 24h results always carry pm=0.
    function automatic hour_t conv_hour(input logic [7:0] h,
                                        input logic       pm,
                                        input fmt_e       to_fmt);
        hour_t res;
        res.hour = h;
        res.pm   = 1'b0;
        if (to_fmt == FMT_12H) begin
            if (h == 8'd0) begin
                res.hour = H12_MAX;
            end else if (h == H12_MAX) begin
                res.pm = 1'b1;
            end else if (h > H12_MAX) begin
                res.hour = h - H12_MAX;
                res.pm   = 1'b1;
            end
        end else begin
            if (h == H12_MAX) begin
                res.hour = pm ? H12_MAX : 8'd0;
            end else begin
                res.hour = pm ? (h + H12_MAX) : h;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_keeper_if.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper_if
// Description : Bundle between the time-setting stage and the running clock.
//               Set side : HC, MC, SC (8b), AmPm, format, load, run
//               Run side : H, M, S (8b), ampm, sec_pulse
//               master = set-stage/driver view, slave = time_keeper view.
// Revision    : 1.0 - initial release
// ============================================================================
interface time_keeper_if;
    logic [7:0] HC;
    logic [7:0] MC;
    logic [7:0] SC;
    logic       AmPm;
    logic       format;
    logic       load;
    logic       run;
    logic [7:0] H;
    logic [7:0] M;
    logic [7:0] S;
    logic       ampm;
    logic       sec_pulse;

    modport master (
        output HC, MC, SC, AmPm, format, load, run,
        input  H, M, S, ampm, sec_pulse
    );

    modport slave (
        input  HC, MC, SC, AmPm, format, load, run,
        output H, M, S, ampm, sec_pulse
    );
endinterface
`default_nettype wire

// File: rtl/time_keeper_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : One-second prescaler. Counts 0..CLK_HZ-1 while run is high,
//               holds while run is low, clears on clear.
//               Ports: clk, reset (async, active-low), run, clear,
//                      tick (high in the cycle whose edge wraps the counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic run,
    input  wire logic clear,
    output logic      tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    // Combinational so the owner can register the pulse and the time
    // advance on the very edge that wraps the counter.
    assign tick = run && !clear && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper
// Description : Running hh:mm:ss clock with 12h/24h format, load with input
//               validation, live format conversion and a per-second pulse.
//               Ports: clk, reset (async, active-low),
//                      bus (time_keeper_if.slave: HC/MC/SC/AmPm/format/load/
//                      run in, H/M/S/ampm/sec_pulse out, all registered).
// Revision    : 1.0 - initial release
// ============================================================================
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     reset,
    time_keeper_if.slave  bus
);

    logic [7:0] r_h, r_m, r_s;
    logic       r_ampm;
    logic       r_pulse;
    logic       r_fmt;
    logic       r_pending;   // second owed from a wrap eaten by a format edge

    logic       w_wrap;
    logic       w_fmt_change;
    logic [7:0] w_ld_h, w_ld_m, w_ld_s;
    logic       w_ld_ampm;
    hour_t      w_cv;
    logic [7:0] w_adv_h, w_adv_m, w_adv_s;
    logic       w_adv_ampm;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (bus.run),
        .clear (bus.load),
        .tick  (w_wrap)
    );

    assign w_fmt_change = (bus.format != r_fmt);

    // Load validation always uses the incoming format, so a load on a
    // format edge needs no separate conversion.
    always_comb begin
        w_ld_m    = (bus.MC > MIN_MAX) ? 8'd0 : bus.MC;
        w_ld_s    = (bus.SC > SEC_MAX) ? 8'd0 : bus.SC;
        w_ld_h    = bus.HC;
        w_ld_ampm = 1'b0;
        if (bus.format == FMT_12H) begin
            if ((bus.HC == 8'd0) || (bus.HC > H12_MAX)) begin
                w_ld_h = H12_MAX;
            end
            w_ld_ampm = bus.AmPm;
        end else if (bus.HC > H24_MAX) begin
            w_ld_h = 8'd0;
        end
    end

    assign w_cv = conv_hour(r_h, r_ampm, fmt_e'(bus.format));

    // One-second advance with carry, in the currently registered format.
    always_comb begin
        w_adv_s    = r_s + 8'd1;
        w_adv_m    = r_m;
        w_adv_h    = r_h;
        w_adv_ampm = r_ampm;
        if (r_s >= SEC_MAX) begin
            w_adv_s = 8'd0;
            if (r_m >= MIN_MAX) begin
                w_adv_m = 8'd0;
                if (r_fmt == FMT_12H) begin
                    if (r_h >= H12_MAX) begin
                        w_adv_h = 8'd1;
                    end else begin
                        w_adv_h = r_h + 8'd1;
                        // 11 -> 12 is where the meridiem flips
                        if (r_h == (H12_MAX - 8'd1)) begin
                            w_adv_ampm = ~r_ampm;
                        end
                    end
                end else begin
                    w_adv_h    = (r_h >= H24_MAX) ? 8'd0 : r_h + 8'd1;
                    w_adv_ampm = 1'b0;
                end
            end else begin
                w_adv_m = r_m + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h       <= 8'd0;
            r_m       <= 8'd0;
            r_s       <= 8'd0;
            r_ampm    <= 1'b0;
            r_pulse   <= 1'b0;
            r_fmt     <= FMT_24H;
            r_pending <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (bus.load) begin
                r_h       <= w_ld_h;
                r_m       <= w_ld_m;
                r_s       <= w_ld_s;
                r_ampm    <= w_ld_ampm;
                r_fmt     <= bus.format;
                r_pending <= 1'b0;
            end else if (w_fmt_change) begin
                r_h       <= w_cv.hour;
                r_ampm    <= w_cv.pm;
                r_fmt     <= bus.format;
                r_pulse   <= w_wrap;
                r_pending <= r_pending | w_wrap;
            end else if (w_wrap || r_pending) begin
                r_h       <= w_adv_h;
                r_m       <= w_adv_m;
                r_s       <= w_adv_s;
                r_ampm    <= w_adv_ampm;
                r_pulse   <= w_wrap;
                // both owed and fresh second: apply one now, keep one owed
                r_pending <= w_wrap & r_pending;
            end
        end
    end

    assign bus.H         = r_h;
    assign bus.M         = r_m;
    assign bus.S         = r_s;
    assign bus.ampm      = r_ampm;
    assign bus.sec_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_keeper
// Description : Directed self-checking bench for time_keeper at CLK_HZ=10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_keeper;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    time_keeper_if bus ();

    time_keeper #(
        .CLK_HZ (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic ap,
                           input logic fmt);
        bus.HC     = h;
        bus.MC     = m;
        bus.SC     = s;
        bus.AmPm   = ap;
        bus.format = fmt;
        bus.load   = 1'b1;
        step(1);
        bus.load   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%0d:%0d:%0d ampm=%0b pulse=%0b exp=0:0:0 ampm=0 pulse=0",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
        step(2);
        reset = 1'b1;
        step(1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_idle got=%0d:%0d:%0d ampm=%0b pulse=%0b exp=all zero",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
    endtask

    task automatic test_rollover_24h();
        int pulses, first, second;
        pulses = 0; first = 0; second = 0;
        bus.run = 1'b1;
        do_load(8'd23, 8'd59, 8'd58, 1'b0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (bus.sec_pulse === 1'b1) begin
                pulses++;
                if (pulses == 1) first = c;
                else if (pulses == 2) second = c;
            end
            if (c == 10) begin
                n_checks++;
                if ({bus.H, bus.M, bus.S, bus.ampm} !== {8'd23, 8'd59, 8'd59, 1'b0}) begin
                    n_fail++;
                    $display("FAIL roll24_mid got=%0d:%0d:%0d/%0b exp=23:59:59/0",
                             bus.H, bus.M, bus.S, bus.ampm);
                end
            end
        end
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== 25'd0) begin
            n_fail++;
            $display("FAIL roll24_wrap got=%0d:%0d:%0d/%0b exp=0:0:0/0",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
        n_checks++;
        if (pulses !== 2 || first !== 10 || second !== 20) begin
            n_fail++;
            $display("FAIL roll24_pulses got n=%0d at %0d,%0d exp n=2 at 10,20",
                     pulses, first, second);
        end
    endtask

    task automatic test_12h();
        bus.run = 1'b1;
        do_load(8'd11, 8'd59, 8'd59, 1'b0, 1'b1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== {8'd11, 8'd59, 8'd59, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL h12_load got=%0d:%0d:%0d/%0b pulse=%0b exp=11:59:59/0 pulse=0",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
        step(10);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== {8'd12, 8'd0, 8'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_noon got=%0d:%0d:%0d/%0b pulse=%0b exp=12:0:0/1 pulse=1",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
        do_load(8'd12, 8'd59, 8'd59, 1'b1, 1'b1);
        step(10);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== {8'd1, 8'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL h12_one_pm got=%0d:%0d:%0d/%0b exp=1:0:0/1",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
        do_load(8'd11, 8'd59, 8'd59, 1'b1, 1'b1);
        step(10);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== {8'd12, 8'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL h12_midnight got=%0d:%0d:%0d/%0b exp=12:0:0/0",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
    endtask

    task automatic test_validation();
        bus.run = 1'b0;
        do_load(8'd30, 8'd75, 8'd60, 1'b1, 1'b0);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== 25'd0) begin
            n_fail++;
            $display("FAIL val_24h got=%0d:%0d:%0d/%0b exp=0:0:0/0",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
        do_load(8'd0, 8'd5, 8'd6, 1'b1, 1'b1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== {8'd12, 8'd5, 8'd6, 1'b1}) begin
            n_fail++;
            $display("FAIL val_12h_zero got=%0d:%0d:%0d/%0b exp=12:5:6/1",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
        do_load(8'd13, 8'd59, 8'd59, 1'b0, 1'b1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== {8'd12, 8'd59, 8'd59, 1'b0}) begin
            n_fail++;
            $display("FAIL val_12h_big got=%0d:%0d:%0d/%0b exp=12:59:59/0",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
    endtask

    task automatic test_format();
        bus.run = 1'b0;
        do_load(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        bus.format = 1'b1;
        step(1);
        n_checks++;
        if ({bus.H, bus.ampm} !== {8'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL cv_0_to_12am got=%0d/%0b exp=12/0", bus.H, bus.ampm);
        end
        do_load(8'd12, 8'd0, 8'd0, 1'b0, 1'b0);
        bus.format = 1'b1;
        step(1);
        n_checks++;
        if ({bus.H, bus.ampm} !== {8'd12, 1'b1}) begin
            n_fail++;
            $display("FAIL cv_12_to_12pm got=%0d/%0b exp=12/1", bus.H, bus.ampm);
        end
        bus.format = 1'b0;
        step(1);
        n_checks++;
        if ({bus.H, bus.ampm} !== {8'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL cv_12pm_to_12 got=%0d/%0b exp=12/0", bus.H, bus.ampm);
        end
        do_load(8'd12, 8'd30, 8'd0, 1'b0, 1'b1);
        bus.format = 1'b0;
        step(1);
        n_checks++;
        if ({bus.H, bus.M, bus.ampm} !== {8'd0, 8'd30, 1'b0}) begin
            n_fail++;
            $display("FAIL cv_12am_to_0 got=%0d:%0d/%0b exp=0:30/0", bus.H, bus.M, bus.ampm);
        end
        do_load(8'd7, 8'd0, 8'd0, 1'b1, 1'b1);
        bus.format = 1'b0;
        step(1);
        n_checks++;
        if ({bus.H, bus.ampm} !== {8'd19, 1'b0}) begin
            n_fail++;
            $display("FAIL cv_7pm_to_19 got=%0d/%0b exp=19/0", bus.H, bus.ampm);
        end

        // format edge landing on the wrap cycle
        bus.run = 1'b1;
        do_load(8'd13, 8'd10, 8'd5, 1'b0, 1'b0);
        step(9);
        bus.format = 1'b1;
        step(1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== {8'd1, 8'd10, 8'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL cv_on_wrap got=%0d:%0d:%0d/%0b pulse=%0b exp=1:10:5/1 pulse=1",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
        step(1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== {8'd1, 8'd10, 8'd6, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL cv_pending got=%0d:%0d:%0d/%0b pulse=%0b exp=1:10:6/1 pulse=0",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
        bus.format = 1'b0;
        step(1);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm} !== {8'd13, 8'd10, 8'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL cv_back_24 got=%0d:%0d:%0d/%0b exp=13:10:6/0",
                     bus.H, bus.M, bus.S, bus.ampm);
        end
    endtask

    task automatic test_async_reset();
        int found;
        found = 0;
        bus.run = 1'b1;
        do_load(8'd5, 8'd5, 8'd5, 1'b0, 1'b0);
        step(3);
        n_checks++;
        if ({bus.H, bus.M, bus.S} !== {8'd5, 8'd5, 8'd5}) begin
            n_fail++;
            $display("FAIL ar_before got=%0d:%0d:%0d exp=5:5:5", bus.H, bus.M, bus.S);
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse} !== 26'd0) begin
            n_fail++;
            $display("FAIL ar_clear got=%0d:%0d:%0d/%0b pulse=%0b exp=0:0:0/0 pulse=0",
                     bus.H, bus.M, bus.S, bus.ampm, bus.sec_pulse);
        end
        #2;
        reset = 1'b1;
        for (int c = 1; c <= 30 && found == 0; c++) begin
            step(1);
            if (bus.sec_pulse === 1'b1) found = c;
        end
        n_checks++;
        if (found !== 10 || {bus.H, bus.M, bus.S} !== {8'd0, 8'd0, 8'd1}) begin
            n_fail++;
            $display("FAIL ar_first_pulse got cycle=%0d time=%0d:%0d:%0d exp cycle=10 time=0:0:1",
                     found, bus.H, bus.M, bus.S);
        end
    endtask

    task automatic test_run_hold();
        int pulses, found;
        pulses = 0;
        found  = 0;
        bus.run = 1'b1;
        do_load(8'd0, 8'd0, 8'd7, 1'b0, 1'b0);
        step(4);
        bus.run = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step(1);
            if (bus.sec_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || {bus.H, bus.M, bus.S} !== {8'd0, 8'd0, 8'd7}) begin
            n_fail++;
            $display("FAIL hold_frozen got pulses=%0d time=%0d:%0d:%0d exp pulses=0 time=0:0:7",
                     pulses, bus.H, bus.M, bus.S);
        end
        bus.run = 1'b1;
        for (int c = 1; c <= 12 && found == 0; c++) begin
            step(1);
            if (bus.sec_pulse === 1'b1) found = c;
        end
        n_checks++;
        if (found !== 6 || bus.S !== 8'd8) begin
            n_fail++;
            $display("FAIL hold_resume got cycle=%0d S=%0d exp cycle=6 S=8", found, bus.S);
        end
        step(9);
        do_load(8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
        n_checks++;
        if ({bus.H, bus.M, bus.S, bus.sec_pulse} !== {8'd2, 8'd3, 8'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL load_on_wrap got=%0d:%0d:%0d pulse=%0b exp=2:3:4 pulse=0",
                     bus.H, bus.M, bus.S, bus.sec_pulse);
        end
        step(9);
        n_checks++;
        if (bus.sec_pulse !== 1'b0 || bus.S !== 8'd4) begin
            n_fail++;
            $display("FAIL load_restart_early got pulse=%0b S=%0d exp pulse=0 S=4",
                     bus.sec_pulse, bus.S);
        end
        step(1);
        n_checks++;
        if (bus.sec_pulse !== 1'b1 || bus.S !== 8'd5) begin
            n_fail++;
            $display("FAIL load_restart_tick got pulse=%0b S=%0d exp pulse=1 S=5",
                     bus.sec_pulse, bus.S);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.HC     = 8'd0;
        bus.MC     = 8'd0;
        bus.SC     = 8'd0;
        bus.AmPm   = 1'b0;
        bus.format = 1'b0;
        bus.load   = 1'b0;
        bus.run    = 1'b0;

        test_reset();
        test_rollover_24h();
        test_12h();
        test_validation();
        test_format();
        test_async_reset();
        test_run_hold();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
